multicycle_alu: RTL and testbench
=================================

// Module: multicycle_alu
// PURPOSE
//  Parametrised sequential ALU for the multicycle datapath. Keeps the existing
//  3-bit op encoding for AND/OR/ADD/SUB/SLT and adds iterative unsigned MUL,
//  DIVU and REMU. Ops are issued with a start/busy/done handshake. The result
//  is held in a register until the next op completes, so control can sample it
//  in any later state.
// PARAMETERS
//  WIDTH       32  operand/result width (>=4)
//  SIGNED_SLT  0   0: SLT compares unsigned; 1: SLT compares two's-complement
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-high reset
//  start        in   1      issue request; accepted only when busy=0
//  a            in   WIDTH  operand A, sampled on the accepted start
//  b            in   WIDTH  operand B, sampled on the accepted start
//  alu_op       in   3      000 AND, 001 OR, 010 ADD, 011 MUL, 100 DIVU,
//                           101 REMU, 110 SUB, 111 SLT
//  result       out  WIDTH  registered result of the last completed op
//  zero         out  1      1 when result == 0 (combinational from result)
//  busy         out  1      1 from the cycle after an accepted start until done
//  done         out  1      one-cycle pulse when result updates
//  div_by_zero  out  1      registered with result: 1 if the last op was DIVU/REMU with b==0
// BEHAVIOUR
//  Reset: state=IDLE, result=0, zero=1, busy=0, done=0, div_by_zero=0.
//   An in-flight op is discarded and produces no done.
//  States: IDLE -> (start & single-cycle op) -> FINISH
//          IDLE -> (start & MUL/DIVU/REMU, b!=0) -> ITER
//          IDLE -> (start & DIVU/REMU, b==0) -> FINISH
//          ITER -> (count==WIDTH-1) -> FINISH
//          FINISH -> IDLE; done=1 for this cycle only
//  Single-cycle ops (AND/OR/ADD/SUB/SLT):
//   - result is written at the edge that accepts start; done=1 next cycle.
//   - Latency 1. busy=0 throughout, so back-to-back issue every 2 cycles.
//  ADD/SUB wrap modulo 2^WIDTH; no carry/overflow output.
//  SLT result is 1 or 0, zero-extended.
//  MUL: shift-add, one bit per cycle, WIDTH iterations; result = low WIDTH bits
//   of a*b. done is asserted WIDTH+1 cycles after the start edge.
//  DIVU/REMU: restoring division, one quotient bit per cycle, WIDTH iterations.
//   Same latency as MUL. DIVU returns the quotient; REMU returns the remainder.
//  b==0 for DIVU/REMU: no iteration, latency 1.
//   - DIVU result = all ones; REMU result = a.
//   - div_by_zero=1. It clears on the next completed op.
//  start while busy=1 is ignored; there is no queueing.
//  start in the FINISH cycle is also ignored: busy=0 but state!=IDLE.
//  Operands and op are latched at accept; input changes afterwards have no effect.
//  result/zero change only on a done cycle or on reset; partials are not visible.
// STRUCTURE
//  Package alu_pkg: ALU_AND..ALU_SLT op localparams, state enum {IDLE, ITER,
//   FINISH}, and an is_iterative(op) function.
//  Sub-module iter_muldiv_unit: owns the accumulator/partial-remainder
//   registers and the iteration counter; takes load, mode and step inputs.
//  Top level holds the FSM, the combinational single-cycle datapath and the
//   result register.
// TESTING
//  1. alu_op=010, a=7, b=5, start -> next cycle done=1, result=12, zero=0,
//     busy stays 0.
//  2. alu_op=110, a=5, b=5 -> result=0, zero=1. Then alu_op=111, a=3,
//     b=32'hFFFF_FFFF with SIGNED_SLT=0 -> result=1; with SIGNED_SLT=1 -> 0.
//  3. alu_op=011, a=32'h0001_0003, b=32'h0001_0002 -> busy=1 for 32 cycles,
//     done at cycle 33, result=32'h0005_0006 (low word).
//  4. alu_op=100, a=100, b=7 -> result=14. alu_op=101, same operands ->
//     result=2, div_by_zero=0.
//  5. DIVU with a=9, b=0 -> done after 1 cycle, result=32'hFFFF_FFFF,
//     div_by_zero=1. REMU with b=0 -> result=9.
//  6. MUL started, then a second start at cycle 10 -> ignored; rst at
//     cycle 20 -> result=0, zero=1, busy=0, no done pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op encodings, FSM states and helpers
// for the multicycle datapath ALU.
package alu_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_MUL  = 3'b011;
  localparam logic [2:0] ALU_DIVU = 3'b100;
  localparam logic [2:0] ALU_REMU = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FINISH
  } state_t;

  function automatic logic is_iterative(input logic [2:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/iter_muldiv_unit.sv
// Bit-serial shift-add multiplier and restoring divider
// sharing one accumulator, shifter and iteration counter.
module iter_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             mode,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] quo_next,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] x_n;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic             mode_q;
  logic [CW-1:0]    count;

  // mode_q=0: acc=product, x=multiplicand, y=multiplier
  // mode_q=1: acc=partial remainder, x=divisor, y=dividend/quotient
  always_comb begin
    rem_sh   = {acc, y[WIDTH-1]};
    diff     = rem_sh - {1'b0, x};
    ge       = ~diff[WIDTH];
    acc_next = acc;
    quo_next = y;
    x_n      = x;
    if (mode_q) begin
      acc_next = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo_next = {y[WIDTH-2:0], ge};
    end else begin
      acc_next = acc + (y[0] ? x : '0);
      quo_next = y >> 1;
      x_n      = x << 1;
    end
  end

  assign last = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      x      <= '0;
      y      <= '0;
      mode_q <= 1'b0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      x      <= mode ? b : a;
      y      <= mode ? a : b;
      mode_q <= mode;
      count  <= '0;
    end else if (step) begin
      acc   <= acc_next;
      x     <= x_n;
      y     <= quo_next;
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus
// iterative MUL/DIVU/REMU behind a start/busy/done handshake.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_SLT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_t           state;
  state_t           next_state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] comb_res;
  logic             slt_bit;
  logic             b_zero;
  logic             load;
  logic             step;
  logic             wr;
  logic             wr_dbz;
  logic [WIDTH-1:0] wr_val;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] quo_next;
  logic             last;

  assign b_zero = (b == '0);

  // Also supplies the divide-by-zero results for DIVU/REMU
  always_comb begin
    slt_bit  = SIGNED_SLT ? ($signed(a) < $signed(b)) : (a < b);
    comb_res = '0;
    unique case (alu_op)
      ALU_AND:  comb_res = a & b;
      ALU_OR:   comb_res = a | b;
      ALU_ADD:  comb_res = a + b;
      ALU_SUB:  comb_res = a - b;
      ALU_SLT:  comb_res = {{(WIDTH-1){1'b0}}, slt_bit};
      ALU_DIVU: comb_res = '1;
      ALU_REMU: comb_res = a;
      default:  comb_res = '0;
    endcase
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    wr         = 1'b0;
    wr_dbz     = 1'b0;
    wr_val     = comb_res;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (is_iterative(alu_op) && !b_zero) begin
            next_state = ITER;
            load       = 1'b1;
          end else begin
            next_state = FINISH;
            wr         = 1'b1;
            wr_dbz     = b_zero &&
                         ((alu_op == ALU_DIVU) ||
                          (alu_op == ALU_REMU));
          end
        end
      end
      ITER: begin
        step = 1'b1;
        if (last) begin
          next_state = FINISH;
          wr         = 1'b1;
          wr_val     = (op_q == ALU_DIVU) ? quo_next : acc_next;
        end
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= ALU_AND;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= next_state;
      if (load) op_q <= alu_op;
      if (wr) begin
        result      <= wr_val;
        div_by_zero <= wr_dbz;
      end
    end
  end

  assign busy = (state == ITER);
  assign done = (state == FINISH);
  assign zero = (result == '0);

  iter_muldiv_unit #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .mode     (alu_op != ALU_MUL),
    .step     (step),
    .a        (a),
    .b        (b),
    .acc_next (acc_next),
    .quo_next (quo_next),
    .last     (last)
  );

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed-vector bench for multicycle_alu with
// unsigned and signed SLT variants side by side.
module tb_multicycle_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alu_op;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] result_s;
  logic        zero_s;
  logic        busy_s;
  logic        done_s;
  logic        dbz_s;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(32), .SIGNED_SLT(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .alu_op(alu_op), .result(result), .zero(zero),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  multicycle_alu #(.WIDTH(32), .SIGNED_SLT(1'b1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .alu_op(alu_op), .result(result_s), .zero(zero_s),
    .busy(busy_s), .done(done_s), .div_by_zero(dbz_s)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, wait for done.
  task automatic run(input logic [2:0] op,
                     input logic [31:0] x, y,
                     output int lat, output int bcyc);
    alu_op = op; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; alu_op = 3'($urandom);
    lat = 1; bcyc = 0;
    while (!done && lat < 100) begin
      if (busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic vec(input string tag, input logic [2:0] op,
                     input logic [31:0] x, y, exp,
                     input int exp_lat, input logic exp_dbz);
    int lat, bcyc;
    run(op, x, y, lat, bcyc);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".busy"}, 32'(bcyc), 32'(exp_lat - 1));
    check({tag, ".res"}, result, exp);
    check({tag, ".zero"}, {31'b0, zero}, {31'b0, exp == 32'h0});
    check({tag, ".dbz"}, {31'b0, div_by_zero}, {31'b0, exp_dbz});
    @(posedge clk); #1;
    check({tag, ".pulse"}, {31'b0, done}, 32'h0);
  endtask

  initial begin
    int lat, bcyc;
    logic saw;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; alu_op = ALU_AND;
    repeat (3) @(posedge clk);
    #1;
    check("rst.res", result, 32'h0);
    check("rst.zero", {31'b0, zero}, 32'h1);
    check("rst.busy", {31'b0, busy}, 32'h0);
    check("rst.done", {31'b0, done}, 32'h0);
    check("rst.dbz", {31'b0, div_by_zero}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    vec("add", ALU_ADD, 32'd7, 32'd5, 32'd12, 1, 1'b0);
    vec("sub", ALU_SUB, 32'd5, 32'd5, 32'd0, 1, 1'b0);
    vec("addwrap", ALU_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1, 1, 1'b0);
    vec("and", ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0,
        32'h0000_00F0, 1, 1'b0);
    vec("or", ALU_OR, 32'h0000_F0F0, 32'h0000_0FF0,
        32'h0000_FFF0, 1, 1'b0);

    run(ALU_SLT, 32'd3, 32'hFFFF_FFFF, lat, bcyc);
    check("sltu.lat", 32'(lat), 32'd1);
    check("sltu.res", result, 32'd1);
    check("slts.res", result_s, 32'd0);
    @(posedge clk); #1;
    run(ALU_SLT, 32'hFFFF_FFFF, 32'd3, lat, bcyc);
    check("sltu2.res", result, 32'd0);
    check("slts2.res", result_s, 32'd1);
    check("slts2.zero", {31'b0, zero_s}, 32'h0);
    @(posedge clk); #1;

    vec("mul", ALU_MUL, 32'h0001_0003, 32'h0001_0002,
        32'h0005_0006, 33, 1'b0);
    vec("mulmax", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'h0000_0001, 33, 1'b0);
    vec("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    vec("remu", ALU_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    vec("divsm", ALU_DIVU, 32'd7, 32'd9, 32'd0, 33, 1'b0);
    vec("remsm", ALU_REMU, 32'd7, 32'd9, 32'd7, 33, 1'b0);
    vec("divmax", ALU_DIVU, 32'hFFFF_FFFF, 32'd1,
        32'hFFFF_FFFF, 33, 1'b0);
    vec("remmax", ALU_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 33, 1'b0);
    vec("div0", ALU_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
    vec("rem0", ALU_REMU, 32'd9, 32'd0, 32'd9, 1, 1'b1);
    vec("dbzclr", ALU_ADD, 32'd1, 32'd2, 32'd3, 1, 1'b0);

    // start held through the FINISH cycle must be ignored
    alu_op = ALU_ADD; a = 32'd7; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    check("fin.done", {31'b0, done}, 32'h1);
    alu_op = ALU_AND; a = '0; b = '0;
    @(posedge clk); #1;
    start = 1'b0;
    check("fin.ign", {31'b0, done}, 32'h0);
    check("fin.res", result, 32'd12);
    @(posedge clk); #1;
    check("fin.idle", {31'b0, done}, 32'h0);

    // MUL, ignored start at cycle 10, async reset at cycle 20
    alu_op = ALU_MUL; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    saw = 1'b0;
    for (int i = 1; i < 10; i++) begin
      saw |= done;
      @(posedge clk); #1;
    end
    alu_op = ALU_ADD; a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign.busy", {31'b0, busy}, 32'h1);
    for (int i = 11; i < 20; i++) begin
      saw |= done;
      @(posedge clk); #1;
    end
    check("ign.done", {31'b0, saw}, 32'h0);
    check("ign.res", result, 32'd12);
    rst = 1'b1;
    #1;
    check("arst.res", result, 32'h0);
    check("arst.zero", {31'b0, zero}, 32'h1);
    check("arst.busy", {31'b0, busy}, 32'h0);
    check("arst.done", {31'b0, done}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      saw |= done | busy;
    end
    check("arst.nodone", {31'b0, saw}, 32'h0);
    check("arst.hold", result, 32'h0);

    vec("post", ALU_MUL, 32'd6, 32'd7, 32'd42, 33, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
